// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, ID layout and source limit.
package irq_ctrl_pkg;

  localparam int unsigned IRQ_MAX_SRC = 6;

  localparam logic [7:0] IRQ_CTRL = 8'h00;
  localparam logic [7:0] IRQ_MASK = 8'h04;
  localparam logic [7:0] IRQ_PEND = 8'h08;
  localparam logic [7:0] IRQ_MODE = 8'h0C;
  localparam logic [7:0] IRQ_ID   = 8'h10;
  localparam logic [7:0] IRQ_RAW  = 8'h14;

  localparam int unsigned IRQ_ID_VALID_BIT = 31;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source input synchronizer with a one-cycle delayed copy for rising-edge detection.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic sys_rstn,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~s_d_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-source sync/qualify/latch, mask and global enable, register
// file on the 8-bit device bus, and the registered HWInt vector.
module irq_controller import irq_ctrl_pkg::*; #(
  parameter int unsigned N_SRC       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   sys_rstn,
  input  logic [7:0]             Addr,
  input  logic                   WE,
  input  logic [31:0]            Din,
  output logic [31:0]            Dout,
  input  logic [N_SRC-1:0]       irq_in,
  output logic [IRQ_MAX_SRC-1:0] HWInt
);

  localparam logic [2:0] SEL_CTRL = IRQ_CTRL[4:2];
  localparam logic [2:0] SEL_MASK = IRQ_MASK[4:2];
  localparam logic [2:0] SEL_PEND = IRQ_PEND[4:2];
  localparam logic [2:0] SEL_MODE = IRQ_MODE[4:2];
  localparam logic [2:0] SEL_ID   = IRQ_ID[4:2];
  localparam logic [2:0] SEL_RAW  = IRQ_RAW[4:2];

  logic [2:0]             sel;
  logic                   wr_ctrl, wr_mask, wr_pend, wr_mode;
  logic [N_SRC-1:0]       lvl, rise, enabled;
  logic                   gen_q;
  logic [N_SRC-1:0]       mask_q, mode_q, pend_q, pend_d;
  logic [IRQ_MAX_SRC-1:0] hwint_q, hwint_d;
  logic [2:0]             id_idx;
  logic [31:0]            id_word;
  logic                   unused_bits;

  assign sel     = Addr[4:2];
  assign wr_ctrl = WE && (sel == SEL_CTRL);
  assign wr_mask = WE && (sel == SEL_MASK);
  assign wr_pend = WE && (sel == SEL_PEND);
  assign wr_mode = WE && (sel == SEL_MODE);

  assign unused_bits = ^{Addr[7:5], Addr[1:0], Din[31:N_SRC]};

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .sys_rstn(sys_rstn),
      .din     (irq_in[g]),
      .lvl     (lvl[g]),
      .rise    (rise[g])
    );
  end

  // Edge mode: a fresh rise beats a same-cycle W1C so no event is lost.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode_q[i]) begin
        pend_d[i] = rise[i] | (pend_q[i] & ~(wr_pend & Din[i]));
      end else begin
        pend_d[i] = lvl[i];
      end
    end
  end

  always_comb begin
    hwint_d = '0;
    if (gen_q) begin
      hwint_d[N_SRC-1:0] = pend_q & mask_q;
    end
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      gen_q   <= 1'b0;
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      hwint_q <= '0;
    end else begin
      if (wr_ctrl) gen_q  <= Din[0];
      if (wr_mask) mask_q <= Din[N_SRC-1:0];
      if (wr_mode) mode_q <= Din[N_SRC-1:0];
      pend_q  <= pend_d;
      hwint_q <= hwint_d;
    end
  end

  assign HWInt   = hwint_q;
  assign enabled = pend_q & mask_q;

  // Scan high to low so the lowest enabled index is the one left standing.
  always_comb begin
    id_idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (enabled[i]) id_idx = 3'(i);
    end
    id_word = '0;
    if (|enabled) begin
      id_word[IRQ_ID_VALID_BIT] = 1'b1;
      id_word[2:0]              = id_idx;
    end
  end

  always_comb begin
    Dout = '0;
    case (sel)
      SEL_CTRL: Dout[0]         = gen_q;
      SEL_MASK: Dout[N_SRC-1:0] = mask_q;
      SEL_PEND: Dout[N_SRC-1:0] = pend_q;
      SEL_MODE: Dout[N_SRC-1:0] = mode_q;
      SEL_ID:   Dout            = id_word;
      SEL_RAW:  Dout[N_SRC-1:0] = lvl;
      default:  Dout            = '0;
    endcase
  end

endmodule
